hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//   Pipeline sequencer for the 5-stage CPU (IF/ID/EX/MEM/WB). Tracks the destination of in-flight
//   instructions in shadow registers and detects RAW hazards against the instruction in ID.
//   Drives PC/IF-ID hold, IF-ID and ID-EX flush (bubble) and EX-stage forwarding selects.
//   Keeps saturating stall/flush cycle counters. Instantiated inside CPU beside the stage modules.
// PARAMETERS
//   CNT_W      16  width of the perf counters stall_cnt / flush_cnt
//   RF_BYPASS  0   1: register file is write-before-read, so a WB-stage producer is not a hazard
// PORTS
//   clk           in   1      clock; all state updates on posedge
//   rst           in   1      synchronous, active-high reset
//   id_valid      in   1      ID holds a real instruction
//   id_rs, id_rt  in   5      source register fields of the ID instruction
//   id_use_rs/rt  in   1      ID instruction actually reads rs / rt
//   id_rd         in   5      destination register of the ID instruction (rt for I-type)
//   id_reg_write  in   1      ID instruction writes the register file
//   id_mem_read   in   1      ID instruction is a load (lw)
//   ex_redirect   in   1      branch taken / jump resolved in EX this cycle
//   pc_stall      out  1      hold PC
//   fd_stall      out  1      hold IF/ID register
//   fd_flush      out  1      clear IF/ID to NOP
//   de_flush      out  1      load bubble into ID/EX
//   fwd_a, fwd_b  out  2      EX operand select: 00 RF, 01 EX/MEM result, 10 MEM/WB result
//   stall_cnt     out  CNT_W  cycles with stall asserted, saturates at all-ones
//   flush_cnt     out  CNT_W  cycles with ex_redirect honoured, saturates at all-ones
// BEHAVIOUR
//   Shadow stages EX, MEM, WB each hold {rd[4:0], wr, ld}. Per posedge: WB<=MEM, MEM<=EX,
//     EX<= (id_valid && !stall && !ex_redirect) ? {id_rd,id_reg_write,id_mem_read} : bubble (wr=0).
//   hit_k = wr_k && rd_k!=0 && ((id_use_rs && id_rs==rd_k) || (id_use_rt && id_rt==rd_k)).
//     Register $0 never hazards.
//   stall (comb) = id_valid && !ex_redirect && hazard, hazard per CONFIGURATION.
//   Outputs are combinational from the shadow registers and inputs:
//     pc_stall = fd_stall = stall; de_flush = stall || ex_redirect; fd_flush = ex_redirect.
//   ex_redirect has priority over stall. The redirecting instruction itself (in EX) completes.
//     The ID instruction is killed (not entered into the EX shadow).
//   FSM: RUN -> STALL on stall; STALL -> STALL while stall; STALL -> RUN on !stall or ex_redirect.
//     The FSM is observable as a state reg for debug. Outputs do not depend on it beyond the above.
//   Counters: +1 per cycle of stall / honoured ex_redirect; hold at 2^CNT_W-1.
//   Reset: shadows = bubble, state = RUN, counters = 0, fwd_a = fwd_b = 00.
//     All comb outputs are forced 0 while rst=1. A reset mid-stall drops the stall in the same cycle.
// CONFIGURATION
//   FORWARD_EN undefined (default):
//     hazard = hit_EX || hit_MEM || (hit_WB && !RF_BYPASS). fwd_a/fwd_b tied to 00.
//     Back-to-back RAW costs 3 stall cycles (2 if RF_BYPASS=1).
//   FORWARD_EN defined:
//     hazard = (hit_EX && ld_EX) || (hit_WB && !RF_BYPASS && !hit_EX && !hit_MEM).
//     fwd_a/fwd_b are registered. Computed from the ID sources on each non-stalled cycle:
//       01 if matching EX shadow (newest wins), else 10 if matching MEM shadow, else 00.
//       Cleared to 00 on a stall/redirect bubble.
//     Load-use costs 1 stall cycle.
// TESTING
//   1 no FORWARD_EN, RF_BYPASS=0: add $3,$1,$2 then sub $4,$3,$1 -> pc_stall high exactly 3 cycles,
//     stall_cnt=3, sub enters EX after the 3rd stall cycle.
//   2 same program, RF_BYPASS=1 -> 2 stall cycles, stall_cnt=2.
//   3 FORWARD_EN: add $3,$1,$2; sub $4,$3,$1 -> 0 stalls, fwd_a=01 while sub in EX.
//     Then lw $9,95($1); add $5,$9,$2 -> 1 stall, fwd_a=10 when the add reaches EX.
//   4 ex_redirect=1 during an active stall -> same cycle: pc_stall=0, fd_flush=1, de_flush=1.
//     flush_cnt+1, FSM -> RUN, killed instruction never hazards later.
//   5 add $0,$1,$2 followed by add $6,$0,$0 (and NOP stream add $0,$0,$0) -> no stall ever.
//   6 rst=1 in 2nd cycle of a stall -> that cycle all outputs 0. Next cycle counters=0, state=RUN,
//     fwd=00, shadows empty.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW hazard detection, stall/flush sequencing and perf counters for the 5-stage pipeline.
// Build option: define FORWARD_EN to enable registered EX-stage forwarding selects.
module hazard_ctrl #(
    parameter int CNT_W     = 16,
    parameter bit RF_BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_redirect,
    output logic             pc_stall,
    output logic             fd_stall,
    output logic             fd_flush,
    output logic             de_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [4:0]       r_ex_rd, r_mem_rd, r_wb_rd;
    logic             r_ex_wr, r_mem_wr, r_wb_wr;
    logic             r_ex_ld;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic             w_hit_ex, w_hit_mem, w_hit_wb;
    logic             w_hazard, w_stall, w_redirect, w_issue;

    function automatic logic f_hit(input logic wr, input logic [4:0] rd,
                                   input logic use_rs, input logic [4:0] rs,
                                   input logic use_rt, input logic [4:0] rt);
        return wr && (rd != 5'd0) && ((use_rs && rs == rd) || (use_rt && rt == rd));
    endfunction

    assign w_hit_ex  = f_hit(r_ex_wr,  r_ex_rd,  id_use_rs, id_rs, id_use_rt, id_rt);
    assign w_hit_mem = f_hit(r_mem_wr, r_mem_rd, id_use_rs, id_rs, id_use_rt, id_rt);
    assign w_hit_wb  = f_hit(r_wb_wr,  r_wb_rd,  id_use_rs, id_rs, id_use_rt, id_rt);

`ifdef FORWARD_EN
    // WB producer still stalls unless a younger EX/MEM match supersedes it
    assign w_hazard = (w_hit_ex && r_ex_ld) ||
                      (w_hit_wb && !RF_BYPASS && !w_hit_ex && !w_hit_mem);
`else
    assign w_hazard = w_hit_ex || w_hit_mem || (w_hit_wb && !RF_BYPASS);
`endif

    // Reset gates every combinational output; redirect overrides stall
    assign w_stall    = !rst && id_valid && !ex_redirect && w_hazard;
    assign w_redirect = !rst && ex_redirect;
    assign w_issue    = id_valid && !w_stall && !ex_redirect;

    assign pc_stall  = w_stall;
    assign fd_stall  = w_stall;
    assign fd_flush  = w_redirect;
    assign de_flush  = w_stall || w_redirect;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_rd  <= '0;
            r_ex_wr  <= 1'b0;
            r_ex_ld  <= 1'b0;
            r_mem_rd <= '0;
            r_mem_wr <= 1'b0;
            r_wb_rd  <= '0;
            r_wb_wr  <= 1'b0;
        end else begin
            r_wb_rd  <= r_mem_rd;
            r_wb_wr  <= r_mem_wr;
            r_mem_rd <= r_ex_rd;
            r_mem_wr <= r_ex_wr;
            r_ex_rd  <= w_issue ? id_rd : '0;
            r_ex_wr  <= w_issue && id_reg_write;
            r_ex_ld  <= w_issue && id_mem_read;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (w_stall) w_state_nxt = ST_STALL;
            ST_STALL: if (!w_stall || w_redirect) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (w_redirect && r_flush_cnt != CNT_MAX) r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

`ifdef FORWARD_EN
    logic [1:0] r_fwd_a, r_fwd_b;

    // Shadows are sampled pre-shift: EX shadow becomes EX/MEM once ID enters EX
    function automatic logic [1:0] f_sel(input logic use_src, input logic [4:0] src,
                                         input logic ex_wr, input logic [4:0] ex_rd,
                                         input logic mem_wr, input logic [4:0] mem_rd);
        if (use_src && ex_wr && ex_rd != 5'd0 && src == ex_rd) return 2'b01;
        if (use_src && mem_wr && mem_rd != 5'd0 && src == mem_rd) return 2'b10;
        return 2'b00;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || w_stall || ex_redirect) begin
            r_fwd_a <= 2'b00;
            r_fwd_b <= 2'b00;
        end else begin
            r_fwd_a <= f_sel(id_use_rs, id_rs, r_ex_wr, r_ex_rd, r_mem_wr, r_mem_rd);
            r_fwd_b <= f_sel(id_use_rt, id_rt, r_ex_wr, r_ex_rd, r_mem_wr, r_mem_rd);
        end
    end

    assign fwd_a = r_fwd_a;
    assign fwd_b = r_fwd_b;
`else
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (RF_BYPASS=0/CNT_W=16 and RF_BYPASS=1/CNT_W=4) against an issue-history model.
// Expectations follow FORWARD_EN when the bench and design are built with it.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } ins_t;

`ifdef FORWARD_EN
    localparam int RAW_ST0 = 0, RAW_ST1 = 0, FWD_ST0 = 1, FWD_ST1 = 1, FWD_N01 = 1, FWD_N10 = 1;
    localparam int RST_AT = 1;
`else
    localparam int RAW_ST0 = 3, RAW_ST1 = 2, FWD_ST0 = 6, FWD_ST1 = 4, FWD_N01 = 0, FWD_N10 = 0;
    localparam int RST_AT = 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ex_redirect;
    logic       id_valid [2];
    logic [4:0] id_rs [2];
    logic [4:0] id_rt [2];
    logic       id_use_rs [2];
    logic       id_use_rt [2];
    logic [4:0] id_rd [2];
    logic       id_reg_write [2];
    logic       id_mem_read [2];

    logic        pc_stall0, fd_stall0, fd_flush0, de_flush0;
    logic        pc_stall1, fd_stall1, fd_flush1, de_flush1;
    logic [1:0]  fwd_a0, fwd_b0, fwd_a1, fwd_b1;
    logic [15:0] stall_cnt0, flush_cnt0;
    logic [3:0]  stall_cnt1, flush_cnt1;

    hazard_ctrl #(.CNT_W(16), .RF_BYPASS(1'b0)) u0 (
        .clk(clk), .rst(rst), .id_valid(id_valid[0]), .id_rs(id_rs[0]), .id_rt(id_rt[0]),
        .id_use_rs(id_use_rs[0]), .id_use_rt(id_use_rt[0]), .id_rd(id_rd[0]),
        .id_reg_write(id_reg_write[0]), .id_mem_read(id_mem_read[0]), .ex_redirect(ex_redirect),
        .pc_stall(pc_stall0), .fd_stall(fd_stall0), .fd_flush(fd_flush0), .de_flush(de_flush0),
        .fwd_a(fwd_a0), .fwd_b(fwd_b0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
    );

    hazard_ctrl #(.CNT_W(4), .RF_BYPASS(1'b1)) u1 (
        .clk(clk), .rst(rst), .id_valid(id_valid[1]), .id_rs(id_rs[1]), .id_rt(id_rt[1]),
        .id_use_rs(id_use_rs[1]), .id_use_rt(id_use_rt[1]), .id_rd(id_rd[1]),
        .id_reg_write(id_reg_write[1]), .id_mem_read(id_mem_read[1]), .ex_redirect(ex_redirect),
        .pc_stall(pc_stall1), .fd_stall(fd_stall1), .fd_flush(fd_flush1), .de_flush(de_flush1),
        .fwd_a(fwd_a1), .fwd_b(fwd_b1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
    );

    logic [7:0]  obs [2];
    logic [31:0] ocnt [2];
    assign obs[0]  = {pc_stall0, fd_stall0, fd_flush0, de_flush0, fwd_a0, fwd_b0};
    assign obs[1]  = {pc_stall1, fd_stall1, fd_flush1, de_flush1, fwd_a1, fwd_b1};
    assign ocnt[0] = {stall_cnt0, flush_cnt0};
    assign ocnt[1] = {12'h000, stall_cnt1, 12'h000, flush_cnt1};

    // Model: ring[k][t%8] holds what was issued into EX at the end of cycle t
    ins_t        ring [2][8];
    ins_t        prog [$];
    int          pc [2];
    int          now;
    logic [1:0]  mfwd_a [2];
    logic [1:0]  mfwd_b [2];
    logic [15:0] ms [2];
    logic [15:0] mf [2];
    logic [7:0]  expv [2];
    logic [31:0] ecnt [2];
    int          nchk, nerr;

    function automatic ins_t mk(input int rs, input int rt, input bit urs, input bit urt,
                                input int rd, input bit wr, input bit ld);
        ins_t i;
        i.v = 1'b1; i.rs = 5'(rs); i.rt = 5'(rt); i.urs = urs; i.urt = urt;
        i.rd = 5'(rd); i.wr = wr; i.ld = ld;
        return i;
    endfunction

    function automatic ins_t rtype(input int rd, input int rs, input int rt);
        return mk(rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0);
    endfunction

    function automatic ins_t lw(input int rt, input int base);
        return mk(base, rt, 1'b1, 1'b0, rt, 1'b1, 1'b1);
    endfunction

    function automatic bit reads(input ins_t e, input logic [4:0] src, input logic use_src);
        return use_src && e.v && e.wr && e.rd != 5'd0 && e.rd == src;
    endfunction

    function automatic bit hit(input int k, input int age, input ins_t i);
        ins_t e = ring[k][(now - age) & 7];
        return reads(e, i.rs, i.urs) || reads(e, i.rt, i.urt);
    endfunction

    function automatic logic [1:0] fsel(input int k, input logic [4:0] src, input logic use_src);
        if (reads(ring[k][(now - 1) & 7], src, use_src)) return 2'b01;
        if (reads(ring[k][(now - 2) & 7], src, use_src)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic load_prog();
        pc[0] = 0;
        pc[1] = 0;
    endtask

    // Presents each instance's next program instruction, then advances the model one cycle
    task automatic cyc(input logic redir, input logic r);
        ins_t cur [2];
        bit h1, h2, h3, hz, st, byp;
        logic [1:0] na, nb;
        logic [15:0] maxv;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            cur[k] = (pc[k] < prog.size()) ? prog[pc[k]] : '0;
            id_valid[k] = cur[k].v;      id_rs[k] = cur[k].rs;      id_rt[k] = cur[k].rt;
            id_use_rs[k] = cur[k].urs;   id_use_rt[k] = cur[k].urt; id_rd[k] = cur[k].rd;
            id_reg_write[k] = cur[k].wr; id_mem_read[k] = cur[k].ld;
        end
        rst = r;
        ex_redirect = redir;
        #1;
        for (int k = 0; k < 2; k++) begin
            byp = (k == 1);
            maxv = (k == 0) ? 16'hFFFF : 16'h000F;
            h1 = hit(k, 1, cur[k]);
            h2 = hit(k, 2, cur[k]);
            h3 = hit(k, 3, cur[k]);
`ifdef FORWARD_EN
            hz = (h1 && ring[k][(now - 1) & 7].ld) || (h3 && !byp && !h1 && !h2);
`else
            hz = h1 || h2 || (h3 && !byp);
`endif
            st = !r && cur[k].v && !redir && hz;
            expv[k] = {st, st, !r && redir, !r && (st || redir), mfwd_a[k], mfwd_b[k]};
            ecnt[k] = {ms[k], mf[k]};
            na = 2'b00;
            nb = 2'b00;
`ifdef FORWARD_EN
            if (!st && !redir) begin
                na = fsel(k, cur[k].rs, cur[k].urs);
                nb = fsel(k, cur[k].rt, cur[k].urt);
            end
`endif
            if (r) begin
                for (int j = 0; j < 8; j++) ring[k][j] = '0;
                mfwd_a[k] = 2'b00;
                mfwd_b[k] = 2'b00;
                ms[k] = '0;
                mf[k] = '0;
            end else begin
                ring[k][now & 7] = (cur[k].v && !st && !redir) ? cur[k] : '0;
                if (st && ms[k] != maxv) ms[k] = ms[k] + 16'd1;
                if (redir && mf[k] != maxv) mf[k] = mf[k] + 16'd1;
                mfwd_a[k] = na;
                mfwd_b[k] = nb;
                if (!st) pc[k] = pc[k] + 1;
            end
        end
        now = now + 1;
    endtask

    task automatic test_reset();
        prog.delete();
        for (int i = 0; i < 8; i++) prog.push_back(rtype($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)));
        load_prog();
        cyc(1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            nchk++;
            if (obs[k][7:4] !== 4'b0000) begin
                nerr++;
                $display("FAIL reset_comb dut%0d: got %b expected 0000", k, obs[k][7:4]);
            end
        end
        cyc(1'b0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < 2; k++) begin
                nchk++;
                if (obs[k] !== expv[k]) begin nerr++; $display("FAIL reset_outs dut%0d t%0d: got %b expected %b", k, now, obs[k], expv[k]); end
                nchk++;
                if (ocnt[k] !== ecnt[k]) begin nerr++; $display("FAIL reset_cnt dut%0d t%0d: got %h expected %h", k, now, ocnt[k], ecnt[k]); end
            end
            cyc(1'b0, 1'b0);
        end
    endtask

    task automatic test_raw();
        int ns0 = 0, ns1 = 0;
        prog.delete();
        prog.push_back(rtype(3, 1, 2));
        prog.push_back(rtype(4, 3, 1));
        load_prog();
        cyc(1'b0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, 1'b0);
            ns0 += int'(pc_stall0);
            ns1 += int'(pc_stall1);
            for (int k = 0; k < 2; k++) begin
                nchk++;
                if (obs[k] !== expv[k]) begin nerr++; $display("FAIL raw_outs dut%0d t%0d: got %b expected %b", k, now, obs[k], expv[k]); end
                nchk++;
                if (ocnt[k] !== ecnt[k]) begin nerr++; $display("FAIL raw_cnt dut%0d t%0d: got %h expected %h", k, now, ocnt[k], ecnt[k]); end
            end
        end
        nchk++;
        if (ns0 != RAW_ST0 || stall_cnt0 !== 16'(RAW_ST0)) begin
            nerr++; $display("FAIL raw_stalls_bypass0: got %0d cycles cnt %0d expected %0d", ns0, stall_cnt0, RAW_ST0);
        end
        nchk++;
        if (ns1 != RAW_ST1 || stall_cnt1 !== 4'(RAW_ST1)) begin
            nerr++; $display("FAIL raw_stalls_bypass1: got %0d cycles cnt %0d expected %0d", ns1, stall_cnt1, RAW_ST1);
        end
    endtask

    task automatic test_forward();
        int ns0 = 0, ns1 = 0, n01 = 0, n10 = 0;
        prog.delete();
        prog.push_back(rtype(3, 1, 2));
        prog.push_back(rtype(4, 3, 1));
        prog.push_back(lw(9, 1));
        prog.push_back(rtype(5, 9, 2));
        load_prog();
        cyc(1'b0, 1'b1);
        for (int c = 0; c < 14; c++) begin
            cyc(1'b0, 1'b0);
            ns0 += int'(pc_stall0);
            ns1 += int'(pc_stall1);
            if (fwd_a0 == 2'b01) n01++;
            if (fwd_a0 == 2'b10) n10++;
            for (int k = 0; k < 2; k++) begin
                nchk++;
                if (obs[k] !== expv[k]) begin nerr++; $display("FAIL fwd_outs dut%0d t%0d: got %b expected %b", k, now, obs[k], expv[k]); end
            end
        end
        nchk++;
        if (ns0 != FWD_ST0 || ns1 != FWD_ST1) begin
            nerr++; $display("FAIL fwd_stalls: got %0d/%0d expected %0d/%0d", ns0, ns1, FWD_ST0, FWD_ST1);
        end
        nchk++;
        if (n01 != FWD_N01 || n10 != FWD_N10) begin
            nerr++; $display("FAIL fwd_select_cycles: got 01x%0d 10x%0d expected 01x%0d 10x%0d", n01, n10, FWD_N01, FWD_N10);
        end
    endtask

    task automatic test_redirect_in_stall();
        int ns = 0;
        prog.delete();
        prog.push_back(lw(3, 1));
        prog.push_back(rtype(4, 3, 1));
        prog.push_back(rtype(7, 4, 0));
        load_prog();
        cyc(1'b0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            cyc(c == 1, 1'b0);
            if (c == 1) begin
                nchk++;
                if ({pc_stall0, fd_flush0, de_flush0, pc_stall1, fd_flush1, de_flush1} !== 6'b011011) begin
                    nerr++; $display("FAIL redirect_prio: got %b expected 011011",
                                     {pc_stall0, fd_flush0, de_flush0, pc_stall1, fd_flush1, de_flush1});
                end
            end
            if (c == 2) begin
                nchk++;
                if (flush_cnt0 !== 16'd1 || flush_cnt1 !== 4'd1) begin
                    nerr++; $display("FAIL redirect_flush_cnt: got %0d/%0d expected 1/1", flush_cnt0, flush_cnt1);
                end
            end
            if (c >= 2) ns += int'(pc_stall0) + int'(pc_stall1);
            for (int k = 0; k < 2; k++) begin
                nchk++;
                if (obs[k] !== expv[k]) begin nerr++; $display("FAIL redir_outs dut%0d t%0d: got %b expected %b", k, now, obs[k], expv[k]); end
                nchk++;
                if (ocnt[k] !== ecnt[k]) begin nerr++; $display("FAIL redir_cnt dut%0d t%0d: got %h expected %h", k, now, ocnt[k], ecnt[k]); end
            end
        end
        nchk++;
        if (ns != 0) begin nerr++; $display("FAIL killed_hazard: got %0d stall cycles expected 0", ns); end
    endtask

    task automatic test_zero_reg();
        int ns = 0;
        prog.delete();
        prog.push_back(rtype(0, 1, 2));
        prog.push_back(rtype(6, 0, 0));
        for (int i = 0; i < 4; i++) prog.push_back(rtype(0, 0, 0));
        load_prog();
        cyc(1'b0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, 1'b0);
            ns += int'(pc_stall0) + int'(pc_stall1);
            for (int k = 0; k < 2; k++) begin
                nchk++;
                if (obs[k] !== expv[k]) begin nerr++; $display("FAIL zero_outs dut%0d t%0d: got %b expected %b", k, now, obs[k], expv[k]); end
            end
        end
        nchk++;
        if (ns != 0 || stall_cnt0 !== 16'd0) begin
            nerr++; $display("FAIL zero_reg_stall: got %0d cycles cnt %0d expected 0", ns, stall_cnt0);
        end
    endtask

    task automatic test_reset_mid_stall();
        prog.delete();
        prog.push_back(lw(3, 1));
        prog.push_back(rtype(4, 3, 1));
        load_prog();
        cyc(1'b0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            cyc(1'b0, c == RST_AT);
            if (c == RST_AT) begin
                nchk++;
                if (obs[0] !== 8'h00 || obs[1] !== 8'h00) begin
                    nerr++; $display("FAIL rst_mid_outs: got %b %b expected 0", obs[0], obs[1]);
                end
            end
            if (c == RST_AT + 1) begin
                nchk++;
                if (ocnt[0] !== 32'h0 || ocnt[1] !== 32'h0 || obs[0] !== 8'h00 || obs[1] !== 8'h00) begin
                    nerr++; $display("FAIL rst_mid_after: got cnt %h %h outs %b %b expected 0", ocnt[0], ocnt[1], obs[0], obs[1]);
                end
            end
            for (int k = 0; k < 2; k++) begin
                nchk++;
                if (obs[k] !== expv[k]) begin nerr++; $display("FAIL rstmid_outs dut%0d t%0d: got %b expected %b", k, now, obs[k], expv[k]); end
            end
        end
    endtask

    task automatic test_saturate();
        prog.delete();
        for (int i = 0; i < 20; i++) prog.push_back(lw(1, 1));
        load_prog();
        cyc(1'b0, 1'b1);
        for (int c = 0; c < 110; c++) begin
            cyc(c >= 90, 1'b0);
            for (int k = 0; k < 2; k++) begin
                nchk++;
                if (ocnt[k] !== ecnt[k]) begin nerr++; $display("FAIL sat_cnt dut%0d t%0d: got %h expected %h", k, now, ocnt[k], ecnt[k]); end
            end
        end
        nchk++;
        if (stall_cnt1 !== 4'hF || flush_cnt1 !== 4'hF) begin
            nerr++; $display("FAIL saturate_hold: got %h/%h expected f/f", stall_cnt1, flush_cnt1);
        end
    endtask

    task automatic test_random();
        ins_t i;
        prog.delete();
        for (int n = 0; n < 450; n++) begin
            i = mk($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0), 1'($urandom));
            i.v = ($urandom_range(0, 7) != 0);
            prog.push_back(i);
        end
        load_prog();
        cyc(1'b0, 1'b1);
        for (int c = 0; c < 400; c++) begin
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
            for (int k = 0; k < 2; k++) begin
                nchk++;
                if (obs[k] !== expv[k]) begin nerr++; $display("FAIL rand_outs dut%0d t%0d: got %b expected %b", k, now, obs[k], expv[k]); end
                nchk++;
                if (ocnt[k] !== ecnt[k]) begin nerr++; $display("FAIL rand_cnt dut%0d t%0d: got %h expected %h", k, now, ocnt[k], ecnt[k]); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        nchk = 0;
        nerr = 0;
        now = 16;
        rst = 1'b1;
        ex_redirect = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 8; j++) ring[k][j] = '0;
            mfwd_a[k] = 2'b00; mfwd_b[k] = 2'b00;
            ms[k] = '0; mf[k] = '0; pc[k] = 0;
            id_valid[k] = 1'b0; id_rs[k] = '0; id_rt[k] = '0; id_use_rs[k] = 1'b0;
            id_use_rt[k] = 1'b0; id_rd[k] = '0; id_reg_write[k] = 1'b0; id_mem_read[k] = 1'b0;
        end
        test_reset();
        test_raw();
        test_forward();
        test_redirect_in_stall();
        test_zero_reg();
        test_reset_mid_stall();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
